// File: rtl/camera_module_pix_in_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : camera_module_pix_in_pkg
//  Description : Shared register map, bit positions and entry format for the
//                camera pixel-input PIO (Avalon-MM slave plus pixel FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
package camera_module_pix_in_pkg;

  // Word offsets of the four slave registers
  typedef enum logic [1:0] {
    REG_DATA      = 2'd0,
    REG_STATUS    = 2'd1,
    REG_CONTROL   = 2'd2,
    REG_THRESHOLD = 2'd3
  } reg_addr_e;

  // STATUS bit positions (level occupies the low bits)
  localparam int c_stat_empty_bit = 16;
  localparam int c_stat_full_bit  = 17;
  localparam int c_stat_stall_bit = 18;

  // CONTROL bit positions; flush and clear-stall are write-only pulses
  localparam int c_ctrl_enable_bit    = 0;
  localparam int c_ctrl_irq_en_bit    = 1;
  localparam int c_ctrl_flush_bit     = 2;
  localparam int c_ctrl_clr_stall_bit = 3;

  // FIFO entry is {sof, pixel[23:0]}
  localparam int c_entry_w       = 25;
  localparam int c_entry_sof_bit = 24;

  // DATA word bit that flags a valid (non-empty) read
  localparam int c_data_valid_bit = 31;

endpackage : camera_module_pix_in_pkg
`default_nettype wire

// File: rtl/camera_module_pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : camera_module_pix_fifo
//  Description : Small synchronous FIFO with flush, occupancy level and
//                empty/full flags. Level carries one extra bit so that a
//                completely full FIFO is distinguishable from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_module_pix_fifo #(
  parameter int WIDTH      = 25,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      din_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow regardless of what the caller does
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  // Next-state pointers and level; flush overrides any push/pop this cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (w_do_push && !w_do_pop)      level_d = level_q + LVL_W'(1);
      else if (w_do_pop && !w_do_push) level_d = level_q - LVL_W'(1);
    end
  end

  // Pointer and level registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule : camera_module_pix_fifo
`default_nettype wire

// File: rtl/camera_module_pio_pix_in.sv
`default_nettype none
// ============================================================================
//  Module      : camera_module_pio_pix_in
//  Description : Avalon-MM slave returning camera pixels to the CPU. Pixels
//                enter through a valid/ready handshake into a FIFO which
//                software drains via a pop-on-read DATA register, with
//                STATUS, CONTROL, THRESHOLD registers and a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_module_pio_pix_in
  import camera_module_pix_in_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [23:0] in_pixel,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic                 enable_q, enable_d;
  logic                 irq_en_q, irq_en_d;
  logic                 stall_q,  stall_d;
  logic                 irq_q,    irq_d;
  logic [LVL_W-1:0]     thresh_q, thresh_d;

  logic [c_entry_w-1:0] w_fifo_head;
  logic [LVL_W-1:0]     w_fifo_level;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;

  reg_addr_e            w_addr;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_ctrl_wr;
  logic                 w_flush;
  logic                 w_clr_stall;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_unused_wdata;

  assign w_addr      = reg_addr_e'(address);
  assign w_wr        = chipselect & ~write_n;
  assign w_rd        = chipselect & ~read_n;
  assign w_ctrl_wr   = w_wr & (w_addr == REG_CONTROL);
  assign w_flush     = w_ctrl_wr & writedata[c_ctrl_flush_bit];
  assign w_clr_stall = w_ctrl_wr & writedata[c_ctrl_clr_stall_bit];

  // Ready depends only on registered state so the source never sees a
  // combinational path from the CPU read strobe.
  assign in_ready = enable_q & ~w_fifo_full;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_rd & (w_addr == REG_DATA) & ~w_fifo_empty;
  assign irq      = irq_q;

  assign w_unused_wdata = ^writedata[31:LVL_W];

  camera_module_pix_fifo #(
    .WIDTH      (c_entry_w),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .din_i   ({in_sof, in_pixel}),
    .dout_o  (w_fifo_head),
    .level_o (w_fifo_level),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  // Register next-state: CONTROL/THRESHOLD writes, sticky stall, irq level
  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    stall_d  = stall_q;
    if (w_ctrl_wr) begin
      enable_d = writedata[c_ctrl_enable_bit];
      irq_en_d = writedata[c_ctrl_irq_en_bit];
    end
    if (w_wr && (w_addr == REG_THRESHOLD)) begin
      thresh_d = writedata[LVL_W-1:0];
    end
    // A fresh stall beats a simultaneous clear so no event is lost
    if (in_valid && enable_q && w_fifo_full) stall_d = 1'b1;
    else if (w_clr_stall)                    stall_d = 1'b0;
    irq_d = irq_en_q & (w_fifo_level >= thresh_q) & (w_fifo_level != '0);
  end

  // Control/status registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      stall_q  <= 1'b0;
      irq_q    <= 1'b0;
      thresh_q <= LVL_W'(1);
    end else begin
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      stall_q  <= stall_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
    end
  end

  // Zero-wait-state read mux; follows address regardless of strobes
  always_comb begin
    readdata = '0;
    unique case (w_addr)
      REG_DATA: begin
        if (!w_fifo_empty) begin
          readdata[c_data_valid_bit]  = 1'b1;
          readdata[c_entry_w-1:0]     = w_fifo_head;
        end
      end
      REG_STATUS: begin
        readdata[LVL_W-1:0]        = w_fifo_level;
        readdata[c_stat_empty_bit] = w_fifo_empty;
        readdata[c_stat_full_bit]  = w_fifo_full;
        readdata[c_stat_stall_bit] = stall_q;
      end
      REG_CONTROL: begin
        readdata[c_ctrl_enable_bit] = enable_q;
        readdata[c_ctrl_irq_en_bit] = irq_en_q;
      end
      REG_THRESHOLD: begin
        readdata[LVL_W-1:0] = thresh_q;
      end
      default: readdata = '0;
    endcase
  end

endmodule : camera_module_pio_pix_in
`default_nettype wire

// File: tb/tb_camera_module_pio_pix_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camera_module_pio_pix_in
//  Description : Directed self-checking bench for camera_module_pio_pix_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_module_pio_pix_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [23:0] in_pixel = '0;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;

  int n_cmp = 0;
  int n_err = 0;

  camera_module_pio_pix_in #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic push_px(input logic [23:0] p, input logic s);
    @(negedge clk);
    in_pixel = p; in_sof = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    bus_read(2'd1, rd); check("rst_status", rd, 32'h0001_0000);
    bus_read(2'd2, rd); check("rst_control", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_thresh", rd, 32'h1);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // ---- basic push / pop-on-read ----
    bus_write(2'd2, 32'h1);
    check("en_in_ready", {31'b0, in_ready}, 32'h1);
    bus_read(2'd2, rd); check("ctrl_readback", rd, 32'h1);
    push_px(24'hABCDEF, 1'b1);
    push_px(24'h123456, 1'b0);
    bus_read(2'd1, rd); check("lvl2", rd, 32'h0000_0002);
    bus_read(2'd0, rd); check("data0", rd, 32'h81AB_CDEF);
    bus_read(2'd1, rd); check("lvl1", rd, 32'h0000_0001);
    bus_read(2'd0, rd); check("data1", rd, 32'h8012_3456);
    bus_read(2'd0, rd); check("data_empty", rd, 32'h0);
    bus_read(2'd1, rd); check("lvl0", rd, 32'h0001_0000);

    // ---- fill to full, stall, one pop re-raises ready ----
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b0;
      in_pixel = (i < 16) ? 24'(32'h100000 + i) : 24'h100010;
      @(posedge clk); #1;
    end
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    bus_read(2'd1, rd); check("full_status", rd, 32'h0006_0010);
    bus_read(2'd0, rd); check("full_head", rd, 32'h8010_0000);
    check("ready_after_pop", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
    bus_write(2'd2, 32'h9);
    bus_read(2'd1, rd); check("stall_clr", rd, 32'h0000_000F);
    bus_read(2'd0, rd); check("order_after_full", rd, 32'h8010_0001);
    bus_write(2'd2, 32'h5);
    bus_read(2'd1, rd); check("flush_idle", rd, 32'h0001_0000);

    // ---- steady push+pop across pointer wrap ----
    for (int i = 0; i < 8; i++) push_px(24'(32'h200000 + i), 1'b0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 24'(32'h200008 + j);
      address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
      #1 check("wrap_data", readdata, 32'h8020_0000 + j);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    bus_read(2'd1, rd); check("wrap_level", rd, 32'h0000_0008);
    for (int k = 0; k < 8; k++) begin
      bus_read(2'd0, rd); check("wrap_drain", rd, 32'h8020_000C + k);
    end
    bus_read(2'd1, rd); check("wrap_empty", rd, 32'h0001_0000);

    // ---- threshold interrupt ----
    bus_write(2'd3, 32'h4);
    bus_write(2'd2, 32'h3);
    for (int i = 0; i < 3; i++) begin
      push_px(24'(32'h300000 + i), 1'b0);
      check("irq_below", {31'b0, irq}, 32'h0);
    end
    push_px(24'h300003, 1'b0);
    check("irq_same_cycle", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_rise", {31'b0, irq}, 32'h1);
    bus_read(2'd0, rd); check("irq_pop_data", rd, 32'h8030_0000);
    check("irq_hold", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_fall", {31'b0, irq}, 32'h0);

    // ---- flush with simultaneous push ----
    bus_write(2'd2, 32'h5);
    for (int i = 0; i < 5; i++) push_px(24'(32'h400000 + i), 1'b0);
    bus_read(2'd1, rd); check("pre_flush", rd, 32'h0000_0005);
    @(negedge clk);
    in_valid = 1'b1; in_pixel = 24'h4000AA;
    address = 2'd2; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd1, rd); check("flush_push", rd, 32'h0001_0000);

    // ---- asynchronous reset with 3 entries ----
    for (int i = 0; i < 3; i++) push_px(24'(32'h500000 + i), 1'b0);
    bus_write(2'd3, 32'h2);
    bus_write(2'd2, 32'h3);
    @(posedge clk); #1;
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); #2;
    address = 2'd1; reset = 1'b1;
    #1;
    check("arst_status", readdata, 32'h0001_0000);
    check("arst_in_ready", {31'b0, in_ready}, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    bus_read(2'd3, rd); check("arst_thresh", rd, 32'h1);
    bus_read(2'd2, rd); check("arst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_camera_module_pio_pix_in
`default_nettype wire

// File: doc/camera_module_pio_pix_in.md
# camera_module_pio_pix_in

Avalon-MM slave that returns camera pixels to the Nios II, the reverse path of the pixel output PIO. A pixel source pushes 24-bit RGB pixels with a start-of-frame flag through a valid/ready handshake into a small synchronous FIFO. Software drains the FIFO through a pop-on-read DATA register and manages it through STATUS, CONTROL and THRESHOLD registers. An optional level interrupt tells the CPU when to drain.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); level field is DEPTH_LOG2+1 bits
- clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- address  in  2  word offset: 0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states
- irq  out  1  level interrupt
- in_pixel  in  24  RGB888 pixel from the source
- in_sof  in  1  marks the first pixel of a frame
- in_valid  in  1  source has a pixel
- in_ready  out  1  block accepts the pixel this cycle

## Operation
- Push: in_valid & in_ready. Stores {in_sof, in_pixel} (25 bits).
- in_ready = enable & ~full. It depends only on registered state, never on a same-cycle pop.
- Stall flag (sticky): set on any cycle with in_valid & enable & full. No data is lost on a stall; the source holds its pixel.
- DATA read returns bit31 = ~empty, bit24 = head sof, bits23:0 = head pixel, other bits 0.
  - When empty, the whole word reads 0.
  - Pop happens when chipselect & ~read_n & address==0 & ~empty.
  - A read of an empty FIFO has no side effect.
- STATUS (read-only): bits[DEPTH_LOG2:0] = level, bit16 = empty, bit17 = full, bit18 = stall. Writes are ignored.
- CONTROL write:
  - bit0 = enable, bit1 = irq_en.
  - bit2 = flush, self-clearing.
  - bit3 = clear stall, self-clearing.
  - Reads back bits1:0 only; bits 2 and 3 always read 0.
- THRESHOLD: bits[DEPTH_LOG2:0], read/write. Reset value 1.
- irq = irq_en & (level >= threshold) & (level != 0). Registered.
- Writes to DATA are ignored. Reads of other addresses have no side effects.
- Clearing enable deasserts in_ready and keeps FIFO contents; software can still drain.

## Timing
- Reset values:
  - readdata follows address. At address 1 it reads 0x0001_0000 (empty=1, level=0).
  - in_ready 0, irq 0, enable 0, irq_en 0, stall 0, THRESHOLD 1, FIFO empty.
- Read latency 0. readdata reflects the head during the read cycle, and the pop takes effect at the closing clock edge.
- A push is visible in DATA and STATUS one cycle after its accepting edge.
- irq follows level with one cycle of delay.
- Push and pop in the same cycle:
  - Non-empty: level unchanged; head advances, tail advances.
  - Empty: the pop is suppressed and the push is accepted.
- Full: in_ready is 0, so no push occurs. A pop that cycle makes in_ready 1 on the next cycle.
- Flush write: pointers and level clear at the write edge. A push accepted in the same cycle is discarded. The stall flag is unaffected.
- Clear-stall and a new stall condition in the same cycle: set wins.
- Pointers wrap modulo 2^DEPTH_LOG2. Level uses an extra bit, so full is level == 2^DEPTH_LOG2.
- Reset asserted mid-transfer: FIFO empties immediately (asynchronous); in_ready and irq go to 0 without waiting for a clock.

## Structure
- Package camera_module_pix_in_pkg holds:
  - register offsets
  - STATUS and CONTROL bit positions
  - ENTRY_W = 25 and the DATA valid bit position (31)
- Sub-module camera_module_pix_fifo: synchronous FIFO parameterised by width and DEPTH_LOG2, with push, pop, flush, level, empty and full. The top level holds the registers, handshake, read mux and irq.

## Test plan
- Reset, then read STATUS: 0x0001_0000. Read CONTROL: 0. Read THRESHOLD: 1. in_ready=0.
- Enable. Push 0xABCDEF with sof=1, then 0x123456. DATA reads 0x81AB_CDEF, then 0x8012_3456, then 0x0000_0000; level goes 2→1→0.
- With enable set, push 16 pixels and hold in_valid: full=1, in_ready=0, stall=1. One DATA read re-raises in_ready the next cycle. Clear stall: bit18=0.
- Fill to 8, then pop while pushing continuously: level stays 8 and data order is preserved across the pointer wrap.
- THRESHOLD=4, irq_en=1: irq rises one cycle after the 4th push and falls one cycle after the level drops to 3.
- Flush with 5 entries while pushing in the same cycle: level 0 and empty next cycle. Assert reset with 3 entries: empty, in_ready=0 and irq=0 immediately.
